// File: rtl/fb_swap_arbiter_pkg.sv
// rtl/fb_swap_arbiter_pkg.sv - shared framebuffer constants and swap-controller state type
package fb_swap_arbiter_pkg;

   localparam int DISPLAY_WIDTH  = 320;
   localparam int DISPLAY_HEIGHT = 240;
   localparam int PIXELS         = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int ADDR_BITS      = 17;

   typedef enum logic [2:0] {
      START,
      RENDER,
      DRAIN,
      WAIT_VSYNC,
      SWAP
   } fb_state_t;

endpackage

// File: rtl/fb_swap_arbiter_rr_arbiter.sv
// rtl/fb_swap_arbiter_rr_arbiter.sv - combinational round-robin grant with pointer update
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_in,
   input  logic          en_in,
   input  logic [PW-1:0] ptr_in,
   output logic [N-1:0]  grant_out,
   output logic [PW-1:0] ptr_nxt_out
);

   int   idx;
   logic found;

   // Scan from ptr_in upward with wrap; the first valid requester wins.
   always_comb begin
      grant_out   = '0;
      ptr_nxt_out = ptr_in;
      found       = 1'b0;
      idx         = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr_in) + off;
         if (idx >= N) idx = idx - N;
         if (en_in && !found && req_in[idx]) begin
            grant_out[idx] = 1'b1;
            found          = 1'b1;
            ptr_nxt_out    = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/fb_swap_arbiter.sv
// rtl/fb_swap_arbiter.sv - double-buffered framebuffer write arbiter with vsync-aligned swap
module fb_swap_arbiter
   import fb_swap_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int ADDR_BITS = fb_swap_arbiter_pkg::ADDR_BITS,
   parameter int PIXELS    = fb_swap_arbiter_pkg::PIXELS
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [NUM_CORES-1:0]           req_valid_in,
   input  logic [NUM_CORES*ADDR_BITS-1:0] req_addr_in,
   input  logic [NUM_CORES*4-1:0]         req_data_in,
   output logic [NUM_CORES-1:0]           req_ready_out,
   input  logic                           frame_done_in,
   input  logic                           vsync_in,
   output logic                           wr_en_out,
   output logic [ADDR_BITS:0]             wr_addr_out,
   output logic [3:0]                     wr_data_out,
   output logic                           display_buf_out,
   output logic                           frame_start_out,
   output logic                           oob_err_out
);

   localparam int PTR_W = $clog2(NUM_CORES);

   fb_state_t            state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 disp_q, disp_d;
   logic                 wr_en_q, wr_en_d;
   logic [ADDR_BITS:0]   wr_addr_q, wr_addr_d;
   logic [3:0]           wr_data_q, wr_data_d;
   logic                 frame_start_q, frame_start_d;
   logic                 oob_q, oob_d;
   logic                 vsync_q, vsync_d;

   logic [NUM_CORES-1:0] grant;
   logic                 arb_en;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [3:0]           sel_data;

   assign arb_en = (state_q == RENDER) || (state_q == DRAIN);

   rr_arbiter #(
      .N  (NUM_CORES),
      .PW (PTR_W)
   ) u_rr_arbiter (
      .req_in      (req_valid_in),
      .en_in       (arb_en),
      .ptr_in      (rr_ptr_q),
      .grant_out   (grant),
      .ptr_nxt_out (rr_ptr_d)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr_in[i*ADDR_BITS +: ADDR_BITS];
            sel_data = req_data_in[i*4 +: 4];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      disp_d        = disp_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_start_d = 1'b0;
      oob_d         = oob_q;
      vsync_d       = vsync_in;

      // Out-of-range writes are swallowed and only leave the sticky flag behind.
      if (|grant) begin
         if (sel_addr < ADDR_BITS'(PIXELS)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {~disp_q, sel_addr};
            wr_data_d = sel_data;
         end else begin
            oob_d = 1'b1;
         end
      end

      case (state_q)
         START: begin
            frame_start_d = 1'b1;
            state_d       = RENDER;
         end
         RENDER:     if (frame_done_in) state_d = DRAIN;
         DRAIN:      if (req_valid_in == '0) state_d = WAIT_VSYNC;
         WAIT_VSYNC: if (vsync_q && !vsync_in) state_d = SWAP;
         SWAP: begin
            disp_d        = ~disp_q;
            frame_start_d = 1'b1;
            state_d       = RENDER;
         end
         default:    state_d = START;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= START;
         rr_ptr_q      <= '0;
         disp_q        <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_start_q <= 1'b0;
         oob_q         <= 1'b0;
         vsync_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         disp_q        <= disp_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_start_q <= frame_start_d;
         oob_q         <= oob_d;
         vsync_q       <= vsync_d;
      end
   end

   assign req_ready_out   = grant;
   assign wr_en_out       = wr_en_q;
   assign wr_addr_out     = wr_addr_q;
   assign wr_data_out     = wr_data_q;
   assign display_buf_out = disp_q;
   assign frame_start_out = frame_start_q;
   assign oob_err_out     = oob_q;

endmodule

// File: tb/tb_fb_swap_arbiter.sv
// tb/tb_fb_swap_arbiter.sv - directed self-checking bench for fb_swap_arbiter
module tb_fb_swap_arbiter;
   import fb_swap_arbiter_pkg::*;

   localparam int NC = 4;
   localparam int AB = 17;

   logic             clk;
   logic             rst;
   logic [NC-1:0]    req_valid;
   logic [NC*AB-1:0] req_addr;
   logic [NC*4-1:0]  req_data;
   logic [NC-1:0]    req_ready;
   logic             frame_done;
   logic             vsync;
   logic             wr_en;
   logic [AB:0]      wr_addr;
   logic [3:0]       wr_data;
   logic             disp_buf;
   logic             frame_start;
   logic             oob_err;

   int n_cmp;
   int n_bad;

   fb_swap_arbiter #(.NUM_CORES(NC), .ADDR_BITS(AB), .PIXELS(76800)) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .req_valid_in    (req_valid),
      .req_addr_in     (req_addr),
      .req_data_in     (req_data),
      .req_ready_out   (req_ready),
      .frame_done_in   (frame_done),
      .vsync_in        (vsync),
      .wr_en_out       (wr_en),
      .wr_addr_out     (wr_addr),
      .wr_data_out     (wr_data),
      .display_buf_out (disp_buf),
      .frame_start_out (frame_start),
      .oob_err_out     (oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int core, input int addr, input int data);
      req_addr[core*AB +: AB] = AB'(addr);
      req_data[core*4 +: 4]   = 4'(data);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst        = 1'b1;
      req_valid  = '0;
      req_addr   = '0;
      req_data   = '0;
      frame_done = 1'b0;
      vsync      = 1'b1;
      tick();
      tick();

      // Reset state
      set_req(0, 5, 4'hA);
      req_valid = 4'b0001;
      settle();
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_disp", int'(disp_buf), 0);
      chk("rst_wren", int'(wr_en), 0);
      chk("rst_oob", int'(oob_err), 0);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_state", int'(dut.state_q), int'(START));

      // Release: START pulses frame_start, then RENDER
      rst = 1'b0;
      tick();
      chk("rel_fs", int'(frame_start), 1);
      chk("rel_disp", int'(disp_buf), 0);
      chk("rel_ready", int'(req_ready), 4'b0001);
      tick();
      chk("w0_en", int'(wr_en), 1);
      chk("w0_addr", int'(wr_addr), 18'h20005);
      chk("w0_data", int'(wr_data), 4'hA);
      chk("w0_fs", int'(frame_start), 0);

      // Core 3 alone brings the pointer back to 0
      set_req(3, 100, 3);
      req_valid = 4'b1000;
      settle();
      chk("c3_ready", int'(req_ready), 4'b1000);
      tick();
      chk("c3_addr", int'(wr_addr), 18'h20064);

      // All cores valid: strict rotation 0,1,2,3,0,1,2,3
      for (int c = 0; c < NC; c++) set_req(c, 16 + c, c + 1);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         settle();
         chk($sformatf("rr_ready%0d", k), int'(req_ready), 1 << (k % 4));
         tick();
         chk($sformatf("rr_addr%0d", k), int'(wr_addr), 18'h20000 + 16 + (k % 4));
         chk($sformatf("rr_data%0d", k), int'(wr_data), (k % 4) + 1);
      end

      // Only core 2: granted every cycle
      req_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("c2_ready%0d", k), int'(req_ready), 4'b0100);
         tick();
         chk($sformatf("c2_en%0d", k), int'(wr_en), 1);
      end

      // frame_done with core 3 granted (ptr=3) while core 1 waits
      set_req(3, 30, 9);
      set_req(1, 7, 5);
      req_valid  = 4'b1010;
      frame_done = 1'b1;
      settle();
      chk("fd_ready", int'(req_ready), 4'b1000);
      tick();
      frame_done = 1'b0;
      req_valid  = 4'b0010;
      chk("fd_addr", int'(wr_addr), 18'h2001E);
      chk("fd_state", int'(dut.state_q), int'(DRAIN));
      settle();
      chk("dr_ready", int'(req_ready), 4'b0010);
      tick();
      chk("dr_addr", int'(wr_addr), 18'h20007);
      chk("dr_data", int'(wr_data), 5);
      req_valid = 4'b0000;
      tick();
      chk("wv_state", int'(dut.state_q), int'(WAIT_VSYNC));
      chk("wv_wren", int'(wr_en), 0);

      // No vsync edge: stay waiting, no grants
      set_req(0, 9, 4'hC);
      req_valid = 4'b0001;
      settle();
      chk("wv_ready", int'(req_ready), 0);
      tick();
      tick();
      tick();
      chk("wv_hold", int'(dut.state_q), int'(WAIT_VSYNC));
      chk("wv_disp", int'(disp_buf), 0);

      // vsync falling edge: SWAP next, toggled buffer the cycle after
      vsync = 1'b0;
      tick();
      chk("sw_state", int'(dut.state_q), int'(SWAP));
      chk("sw_disp", int'(disp_buf), 0);
      chk("sw_ready", int'(req_ready), 0);
      tick();
      chk("sw2_disp", int'(disp_buf), 1);
      chk("sw2_fs", int'(frame_start), 1);
      chk("sw2_state", int'(dut.state_q), int'(RENDER));
      settle();
      chk("sw2_ready", int'(req_ready), 4'b0001);
      tick();
      chk("nf_addr", int'(wr_addr), 18'h00009);
      chk("nf_fs", int'(frame_start), 0);

      // vsync edge during RENDER is ignored
      req_valid = 4'b0000;
      vsync     = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
      tick();
      chk("rv_disp", int'(disp_buf), 1);
      chk("rv_state", int'(dut.state_q), int'(RENDER));

      // Last in-range pixel, then the first out-of-range one
      set_req(3, 76799, 4'h7);
      req_valid = 4'b1000;
      tick();
      chk("edge_en", int'(wr_en), 1);
      chk("edge_addr", int'(wr_addr), 18'h12BFF);
      chk("edge_oob", int'(oob_err), 0);
      set_req(3, 76800, 4'hF);
      tick();
      req_valid = 4'b0000;
      chk("oob_en", int'(wr_en), 0);
      chk("oob_flag", int'(oob_err), 1);
      tick();
      tick();
      chk("oob_sticky", int'(oob_err), 1);

      // Reset during DRAIN with a handshake in flight
      set_req(2, 40, 2);
      req_valid  = 4'b0100;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      chk("rd_state", int'(dut.state_q), int'(DRAIN));
      settle();
      chk("rd_ready", int'(req_ready), 4'b0100);
      rst = 1'b1;
      tick();
      chk("rd_wren", int'(wr_en), 0);
      chk("rd_disp", int'(disp_buf), 0);
      chk("rd_st", int'(dut.state_q), int'(START));
      chk("rd_oob", int'(oob_err), 0);
      chk("rd_fs", int'(frame_start), 0);
      req_valid = 4'b0000;
      rst       = 1'b0;
      tick();
      chk("rd_fs_pulse", int'(frame_start), 1);
      tick();
      chk("rd_fs_end", int'(frame_start), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
